fft_frame_loader: RTL and testbench
===================================

// Module: fft_frame_loader
// PURPOSE
// - Serial-to-parallel front end for the 8-point FFT (fft_1).
// - Accepts one complex Q10.6 sample per cycle over a valid/ready stream.
// - Assembles frames of N samples in ping-pong banks and presents each frame as a parallel lane bus to the FFT.
// - Lets the upstream demapper or OFDM symbol source stream continuously at 1 sample/clk with no bubbles.
// PARAMETERS
// - DW    16  sample width per component; two's complement; Q10.6 (FRAC=6)
// - N     8   FFT points per frame; must be a power of 2
// - CNTW  16  width of the delivered-frame counter
// PORTS
// - clk        in   1       rising-edge clock; the only clock
// - reset      in   1       synchronous, active-low reset; sampled on the clk rising edge
// - s_valid    in   1       input sample valid
// - s_ready    out  1       loader can accept a sample
// - s_re       in   DW      input sample, real part
// - s_im       in   DW      input sample, imaginary part
// - s_last     in   1       marks the final sample of a frame
// - f_valid    out  1       a full frame is presented on x_re/x_im
// - f_ready    in   1       FFT consumes the frame; tie to 1 for fft_1
// - x_re       out  N*DW    frame real parts; lane k = bits [k*DW +: DW]; feeds x_re0..x_re7
// - x_im       out  N*DW    frame imaginary parts; same lane packing as x_re
// - frame_err  out  1       one-cycle pulse: s_last arrived before lane N-1
// - frame_cnt  out  CNTW    count of frames delivered (f_valid & f_ready); wraps
// BEHAVIOUR
// - State:
//   - two banks, A and B, each N x (re, im)
//   - wr_bank and rd_bank, 1b each
//   - wr_idx, log2(N) bits
//   - full[1:0], one flag per bank
// - Reset (reset==0 at a clk edge):
//   - all storage cleared to 0
//   - wr_bank = rd_bank = 0, wr_idx = 0, full = 0
//   - frame_cnt = 0, frame_err = 0
//   - outputs after reset: s_ready=1, f_valid=0, x_re=x_im=0
//   - a reset mid-frame discards the partial frame and any frame that has not been consumed.
// - Accept: a sample is taken when s_valid & s_ready.
//   - Write goes to bank[wr_bank], lane L(wr_idx); wr_idx increments.
// - Frame complete: an accept with wr_idx==N-1.
//   - Sets full[wr_bank], toggles wr_bank, and clears wr_idx.
//   - s_last is optional at that position.
// - Early s_last: an accept with s_last=1 and wr_idx<N-1.
//   - That sample is written, then the frame is dropped: wr_idx=0, no full set.
//   - frame_err pulses high for one cycle.
// - s_ready = !full[wr_bank], combinational.
// - f_valid = full[rd_bank].
//   - x_re/x_im are driven from bank[rd_bank] and are stable while f_valid=1 and f_ready=0.
// - Consume: f_valid & f_ready clears full[rd_bank], toggles rd_bank, and increments frame_cnt.
// - A fill and a consume in the same cycle touch different banks; both take effect.
// - Latency: lane N-1 accepted at edge k gives f_valid=1 in the cycle after edge k.
// - Throughput: with f_ready=1, s_ready never deasserts, so 1 sample/clk is sustained.
//   - With f_ready=0, at most 2 frames are buffered; s_ready drops once both banks are full.
// - Data passes through with no arithmetic, scaling or saturation; widths are preserved bit-exactly.
// CONFIGURATION
// - FFT_IN_BITREV_EN defined: lane L(i) = bitrev_log2N(i).
//   - For N=8, samples 0..7 go to lanes 0,4,2,6,1,5,3,7 (DIT-ready order).
// - FFT_IN_BITREV_EN undefined: L(i) = i (natural order, which fft_1 expects).
// STRUCTURE
// - fft_pkg holds:
//   - FFT_DW, FFT_FRAC, FFT_N
//   - typedef cplx_t {logic signed [DW-1:0] re, im;}
//   - function bitrev(idx, log2n)
// - Sub-module fft_frame_bank: one N-entry complex register bank.
//   - Inputs: we, waddr, wdata, clr. Output: flat lane bus.
//   - Instantiated twice.
// - The top level holds the counters, full flags, bank select mux and handshake logic.
// TESTING
// - Reset, then stream s_re = 64,45,0,45,64,-46,-65,-46 with s_im=0 and f_ready=1.
//   - Expect f_valid one cycle after the 8th accept, x_re lane k matching the k-th sample, and frame_cnt=1.
// - Back-to-back: 4 frames with s_valid=1 and f_ready=1 continuously.
//   - Expect s_ready constantly 1, f_valid pulses every 8 clk, frame_cnt=4.
// - Backpressure: f_ready=0 while 2 frames are pushed.
//   - Expect s_ready=0 after the 16th accept and x_re to hold frame 1.
//   - Then f_ready=1 for 1 cycle: frame 2 is presented and s_ready returns to 1.
// - Early s_last on the 5th sample.
//   - Expect a frame_err pulse, no f_valid; the next 8 samples form a clean frame.
// - Reset asserted (reset=0) after 3 samples of a frame.
//   - Expect all outputs at reset values; the following 8 samples give a correct frame.
// - Build with FFT_IN_BITREV_EN and feed samples 0..7.
//   - Expect x_re lanes = 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample type and index helpers for the FFT front end.
package fft_pkg;

    localparam int FFT_DW   = 16;
    localparam int FFT_FRAC = 6;
    localparam int FFT_N    = 8;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    // Reverse the low log2n bits of idx (DIT input ordering).
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned log2n);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < log2n; b++) begin
            r = (r << 1) | ((idx >> b) & 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry complex register bank with a single write port and all lanes
// exposed in parallel as flat buses.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int N  = FFT_N,
    parameter int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [2*DW-1:0] wdata,
    output logic [N*DW-1:0] lane_re,
    output logic [N*DW-1:0] lane_im
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [DW-1:0] re_reg;
            logic [DW-1:0] im_reg;

            // wdata is packed as {re, im}
            always_ff @(posedge clk) begin
                if (clr) begin
                    re_reg <= '0;
                    im_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    re_reg <= wdata[2*DW-1:DW];
                    im_reg <= wdata[DW-1:0];
                end
            end

            assign lane_re[gi*DW +: DW] = re_reg;
            assign lane_im[gi*DW +: DW] = im_reg;
        end
    endgenerate

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong serial-to-parallel frame loader feeding the 8-point FFT.
// Define FFT_IN_BITREV_EN to store samples in bit-reversed lane order.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int DW   = FFT_DW,
    parameter int N    = FFT_N,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_re,
    input  logic [DW-1:0]   s_im,
    input  logic            s_last,
    output logic            f_valid,
    input  logic            f_ready,
    output logic [N*DW-1:0] x_re,
    output logic [N*DW-1:0] x_im,
    output logic            frame_err,
    output logic [CNTW-1:0] frame_cnt
);

    localparam int LW = $clog2(N);

    logic            wr_bank_reg;
    logic            rd_bank_reg;
    logic [LW-1:0]   wr_idx_reg;
    logic [1:0]      full_reg;
    logic [CNTW-1:0] frame_cnt_reg;
    logic            frame_err_reg;

    logic            accept;
    logic            consume;
    logic [LW-1:0]   lane;
    logic [N*DW-1:0] a_re, a_im, b_re, b_im;

    assign s_ready = !full_reg[wr_bank_reg];
    assign f_valid = full_reg[rd_bank_reg];
    assign accept  = s_valid && s_ready;
    assign consume = f_valid && f_ready;

`ifdef FFT_IN_BITREV_EN
    assign lane = LW'(bitrev(32'(wr_idx_reg), LW));
`else
    assign lane = wr_idx_reg;
`endif

    // Reset clears bank contents so x_re/x_im read zero afterwards.
    fft_frame_bank #(.DW(DW), .N(N), .AW(LW)) u_bank_a (
        .clk     (clk),
        .clr     (!reset),
        .we      (accept && !wr_bank_reg),
        .waddr   (lane),
        .wdata   ({s_re, s_im}),
        .lane_re (a_re),
        .lane_im (a_im)
    );

    fft_frame_bank #(.DW(DW), .N(N), .AW(LW)) u_bank_b (
        .clk     (clk),
        .clr     (!reset),
        .we      (accept && wr_bank_reg),
        .waddr   (lane),
        .wdata   ({s_re, s_im}),
        .lane_re (b_re),
        .lane_im (b_im)
    );

    assign x_re      = rd_bank_reg ? b_re : a_re;
    assign x_im      = rd_bank_reg ? b_im : a_im;
    assign frame_err = frame_err_reg;
    assign frame_cnt = frame_cnt_reg;

    // A fill sets full[wr_bank] (which was clear) while a consume clears
    // full[rd_bank] (which was set), so the two never target the same bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            wr_idx_reg    <= '0;
            full_reg      <= 2'b00;
            frame_cnt_reg <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            if (accept) begin
                if (wr_idx_reg == LW'(N-1)) begin
                    full_reg[wr_bank_reg] <= 1'b1;
                    wr_bank_reg           <= !wr_bank_reg;
                    wr_idx_reg            <= '0;
                end else if (s_last) begin
                    wr_idx_reg    <= '0;
                    frame_err_reg <= 1'b1;
                end else begin
                    wr_idx_reg <= wr_idx_reg + 1'b1;
                end
            end
            if (consume) begin
                full_reg[rd_bank_reg] <= 1'b0;
                rd_bank_reg           <= !rd_bank_reg;
                frame_cnt_reg         <= frame_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed plus randomized bench for fft_frame_loader against a queue-based
// frame model; honours FFT_IN_BITREV_EN for the expected lane order.
module tb_fft_frame_loader;

    localparam int DW   = 16;
    localparam int N    = 8;
    localparam int CNTW = 16;
    localparam int LW   = 3;
    localparam int XW   = N * DW;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_re = '0;
    logic [DW-1:0]   s_im = '0;
    logic            s_last = 1'b0;
    logic            f_valid;
    logic            f_ready = 1'b0;
    logic [XW-1:0]   x_re;
    logic [XW-1:0]   x_im;
    logic            frame_err;
    logic [CNTW-1:0] frame_cnt;

    always #5 clk = ~clk;

    fft_frame_loader #(.DW(DW), .N(N), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_re      (s_re),
        .s_im      (s_im),
        .s_last    (s_last),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .x_re      (x_re),
        .x_im      (x_im),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: completed frames waiting for the FFT, already laid out
    // as lane buses, plus the frame currently being assembled.
    logic [XW-1:0] q_re[$];
    logic [XW-1:0] q_im[$];
    logic [DW-1:0] cur_re[N];
    logic [DW-1:0] cur_im[N];
    int            idx = 0;
    int unsigned   cnt = 0;
    bit            err = 1'b0;
    bit            zero_x = 1'b0;

    function automatic int lane_of(input int i);
`ifdef FFT_IN_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < LW; b++) begin
            if ((i & (1 << b)) != 0) r += 1 << (LW - 1 - b);
        end
        return r;
`else
        return i;
`endif
    endfunction

    task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance
    // the model by what the edge should do.
    task automatic step(input bit rst, input bit v, input logic [DW-1:0] re,
                        input logic [DW-1:0] im, input bit last, input bit fr, input bit chk);
        bit acc;
        bit cons;
        logic [XW-1:0] bre;
        logic [XW-1:0] bim;
        @(negedge clk);
        reset   = ~rst;
        s_valid = v;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        f_ready = fr;
        if (chk) begin
            check("s_ready", XW'(s_ready), XW'(q_re.size() < 2));
            check("f_valid", XW'(f_valid), XW'(q_re.size() > 0));
            check("frame_cnt", XW'(frame_cnt), XW'(cnt % 65536));
            check("frame_err", XW'(frame_err), XW'(err));
            if (q_re.size() > 0) begin
                check("x_re", x_re, q_re[0]);
                check("x_im", x_im, q_im[0]);
            end else if (zero_x) begin
                check("x_re_zero", x_re, '0);
                check("x_im_zero", x_im, '0);
            end
        end
        @(posedge clk);
        if (rst) begin
            q_re.delete();
            q_im.delete();
            idx    = 0;
            cnt    = 0;
            err    = 1'b0;
            zero_x = 1'b1;
        end else begin
            acc  = v && (q_re.size() < 2);
            cons = fr && (q_re.size() > 0);
            err  = 1'b0;
            if (cons) begin
                cnt++;
                $display("frame %0d delivered x_re=%h x_im=%h", cnt, q_re[0], q_im[0]);
                void'(q_re.pop_front());
                void'(q_im.pop_front());
            end
            if (acc) begin
                zero_x      = 1'b0;
                cur_re[idx] = re;
                cur_im[idx] = im;
                if (idx == N - 1) begin
                    bre = '0;
                    bim = '0;
                    for (int i = 0; i < N; i++) begin
                        bre[lane_of(i)*DW +: DW] = cur_re[i];
                        bim[lane_of(i)*DW +: DW] = cur_im[i];
                    end
                    q_re.push_back(bre);
                    q_im.push_back(bim);
                    idx = 0;
                end else if (last) begin
                    idx = 0;
                    err = 1'b1;
                end else begin
                    idx++;
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit fr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, fr, 1'b1);
    endtask

    // n random samples, s_last on sample last_at (or never when last_at < 0).
    task automatic rand_samples(input int n, input int last_at, input bit fr);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, DW'($urandom), DW'($urandom), (i == last_at), fr, 1'b1);
        end
    endtask

    int t1[N] = '{64, 45, 0, 45, 64, -46, -65, -46};

    initial begin
        // Reset and reset-value check
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);

        // Known frame with f_ready=1
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, DW'(t1[i]), '0, (i == N - 1), 1'b1, 1'b1);
        end
        idle(2, 1'b1);

        // Four back-to-back frames
        for (int f = 0; f < 4; f++) rand_samples(N, N - 1, 1'b1);
        idle(2, 1'b1);

        // Backpressure: two frames buffered, then stalls, then one consume
        rand_samples(2 * N, -1, 1'b0);
        rand_samples(3, -1, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Early s_last on the 5th sample, then a clean frame
        rand_samples(5, 4, 1'b1);
        rand_samples(N, -1, 1'b1);
        idle(2, 1'b1);

        // Reset after 3 samples, then a clean frame
        rand_samples(3, -1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        rand_samples(N, N - 1, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Ramp 0..7 shows the lane ordering directly
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, DW'(i), DW'(100 + i), 1'b0, 1'b0, 1'b1);
        end
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), DW'($urandom), DW'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0), 1'b1);
        end
        idle(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
